multi_blinker: RTL

MULTI_BLINKER -- requirements
Module: multi_blinker

---
 rtl/multi_blinker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multi_blinker.sv
// -----------------------------------------------------------------------------
// multi_blinker
//
// Bank of independent blink channels. Each channel holds a latched mode and
// two phase lengths (high/low, each stored as length-1). A single shared
// configuration port writes one channel per accepted transfer; the write
// takes effect at the transfer edge itself, restarting that channel cleanly
// while every other channel keeps running.
//
// Channel states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | not blinking; light is 1 for mode ON, otherwise 0
//   HIGH    | high phase, counter runs 0..on, light = 1
//   LOW     | low phase (CONT only), counter runs 0..off, light = 0
//
// Ports:
//   clk        in   clock, all state changes on posedge
//   rst        in   asynchronous active-high reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration can be accepted (registered)
//   cfg_ch     in   target channel index (out-of-range indices are ignored)
//   cfg_mode   in   0=OFF 1=CONT 2=ONESHOT 3=ON
//   cfg_on     in   high-phase length minus 1
//   cfg_off    in   low-phase length minus 1
//   light      out  registered per-channel output
//   busy       out  per-channel flag, 1 while in HIGH or LOW
// -----------------------------------------------------------------------------
module multi_blinker #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_on,
    input  logic [CNT_W-1:0]    cfg_off,
    output logic [CHANNELS-1:0] light,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_CONT    = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_ON      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Configuration handshake. Ready comes up one edge after reset is
    // released, so the first edge after release never accepts a transfer.
    // ------------------------------------------------------------------
    logic cfg_ready_q;
    logic cfg_ready_d;
    logic xfer;

    always_comb begin
        cfg_ready_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign xfer      = cfg_valid & cfg_ready_q;

    // ------------------------------------------------------------------
    // Per-channel FSMs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] on_q;
        logic [CNT_W-1:0] on_d;
        logic [CNT_W-1:0] off_q;
        logic [CNT_W-1:0] off_d;
        logic [1:0]       mode_q;
        logic [1:0]       mode_d;
        logic             light_q;
        logic             light_d;
        logic             busy_c;
        logic             hit;

        assign hit = xfer && (cfg_ch == CH_W'(gi));

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                on_q    <= '0;
                off_q   <= '0;
                mode_q  <= MODE_OFF;
                light_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                on_q    <= on_d;
                off_q   <= off_d;
                mode_q  <= mode_d;
                light_q <= light_d;
            end
        end

        // Next-state logic. A transfer overrides whatever phase is running,
        // so reconfiguring an active channel restarts it at the same edge.
        // The counter is compared for equality before incrementing, so it
        // never passes the compare value even when that is all-ones.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            on_d    = on_q;
            off_d   = off_q;
            mode_d  = mode_q;

            if (hit) begin
                mode_d = cfg_mode;
                on_d   = cfg_on;
                off_d  = cfg_off;
                cnt_d  = '0;
                if ((cfg_mode == MODE_CONT) || (cfg_mode == MODE_ONESHOT)) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                unique case (state_q)
                    ST_HIGH: begin
                        if (cnt_q == on_q) begin
                            cnt_d = '0;
                            if (mode_q == MODE_CONT) begin
                                state_d = ST_LOW;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q == off_q) begin
                            cnt_d   = '0;
                            state_d = ST_HIGH;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // Output logic. light is registered from the next state so it lines
        // up with the state it describes, with no extra cycle of latency.
        // A finished ONESHOT lands in IDLE with mode ONESHOT, hence light 0.
        always_comb begin
            light_d = (state_d == ST_HIGH) ||
                      ((state_d == ST_IDLE) && (mode_d == MODE_ON));
            busy_c  = (state_q == ST_HIGH) || (state_q == ST_LOW);
        end

        assign light[gi] = light_q;
        assign busy[gi]  = busy_c;
    end

endmodule
